// File: rtl/cart_pkg.sv
// Shared constants, op codes, FSM states and the default unit-price table
// for the cart_register totaliser.
package cart_pkg;

    localparam int N_ITEMS = 12;
    localparam int CNT_W   = 4;
    localparam int PRICE_W = 16;
    localparam int IDX_W   = 4;
    localparam int SLOT_W  = CNT_W + PRICE_W;
    localparam int NUM_W   = N_ITEMS * SLOT_W;
    localparam int PROD_W  = CNT_W + PRICE_W;

    localparam logic [CNT_W-1:0]   QTY_MAX   = CNT_W'(15);
    localparam logic [PRICE_W-1:0] PRICE_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        OP_ADD       = 2'd0,
        OP_REMOVE    = 2'd1,
        OP_SET_PRICE = 2'd2,
        OP_CLEAR     = 2'd3
    } cart_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        SUM  = 1'b1
    } cart_state_e;

    function automatic logic [PRICE_W-1:0] default_price(input int k);
        return PRICE_W'(100 * (k + 1));
    endfunction

endpackage

// File: rtl/cart_register_if.sv
// Command handshake from the keypad controller and the cart/total buses
// consumed by the price display writer.
interface cart_register_if;
    import cart_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [IDX_W-1:0]     cmd_idx;
    logic [PRICE_W-1:0]   cmd_price;
    logic [NUM_W-1:0]     numbers;
    logic [SLOT_W-1:0]    total_price;
    logic                 total_valid;
    logic                 overflow;
    logic                 cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_price,
        input  cmd_ready, numbers, total_price, total_valid, overflow, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_price,
        output cmd_ready, numbers, total_price, total_valid, overflow, cmd_err
    );

endinterface

// File: rtl/cart_mac.sv
// Registered saturating multiply-accumulate for the cart total sweep:
// accumulates qty*price and qty, clamping each and flagging any clamp.
module cart_mac
    import cart_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step,
    input  logic [CNT_W-1:0]   qty,
    input  logic [PRICE_W-1:0] price,
    output logic [CNT_W-1:0]   acc_qty,
    output logic [PRICE_W-1:0] acc_price,
    output logic               sat
);

    logic [PROD_W-1:0] product;
    logic [PROD_W:0]   price_sum;
    logic [CNT_W:0]    qty_sum;
    logic              price_clip;
    logic              qty_clip;

    assign product    = PROD_W'(qty) * PROD_W'(price);
    assign price_sum  = (PROD_W + 1)'(acc_price) + (PROD_W + 1)'(product);
    assign qty_sum    = (CNT_W + 1)'(acc_qty) + (CNT_W + 1)'(qty);
    assign price_clip = price_sum > (PROD_W + 1)'(PRICE_MAX);
    assign qty_clip   = qty_sum > (CNT_W + 1)'(QTY_MAX);

    // NOTE: state is written with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_qty   <= '0;
            acc_price <= '0;
            sat       <= 1'b0;
        end else if (clr) begin
            acc_qty   <= '0;
            acc_price <= '0;
            sat       <= 1'b0;
        end else if (step) begin
            acc_price <= price_clip ? PRICE_MAX : price_sum[PRICE_W-1:0];
            acc_qty   <= qty_clip ? QTY_MAX : qty_sum[CNT_W-1:0];
            sat       <= sat | price_clip | qty_clip;
        end
    end

endmodule

// File: rtl/cart_register.sv
// Cart state holder and totaliser. Define CART_PRICE_LOAD_EN to make unit
// prices writable via SET_PRICE; otherwise prices are the package constants.
module cart_register
    import cart_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    cart_register_if.slave  bus
);

    cart_state_e        state_q, state_d;
    logic [IDX_W-1:0]   sum_idx_q;
    logic [CNT_W-1:0]   qty_q [N_ITEMS];
    logic [PRICE_W-1:0] price [N_ITEMS];

    cart_op_e           op;
    logic               accept, idx_ok, recompute;
    logic               mac_clr, mac_step, latch_total;
    logic [CNT_W-1:0]   cmd_qty, sel_qty, acc_qty;
    logic [PRICE_W-1:0] sel_price, acc_price;
    logic               mac_sat;

    assign op            = cart_op_e'(bus.cmd_op);
    assign bus.cmd_ready = (state_q == IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign idx_ok        = bus.cmd_idx < IDX_W'(N_ITEMS);

`ifdef CART_PRICE_LOAD_EN
    localparam bit PRICE_LOAD = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ITEMS; k++) price[k] <= default_price(k);
        end else if (accept && op == OP_SET_PRICE) begin
            for (int k = 0; k < N_ITEMS; k++)
                if (bus.cmd_idx == IDX_W'(k)) price[k] <= bus.cmd_price;
        end
    end
`else
    localparam bit PRICE_LOAD = 1'b0;
    logic unused_price;

    assign unused_price = ^bus.cmd_price;
    always_comb begin
        for (int k = 0; k < N_ITEMS; k++) price[k] = default_price(k);
    end
`endif

    // SET_PRICE only changes the total when prices are writable.
    assign recompute = accept &&
        (op == OP_CLEAR || (idx_ok && (op != OP_SET_PRICE || PRICE_LOAD)));

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        cmd_qty   = '0;
        sel_qty   = '0;
        sel_price = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (bus.cmd_idx == IDX_W'(k)) cmd_qty = qty_q[k];
            if (sum_idx_q == IDX_W'(k)) begin
                sel_qty   = qty_q[k];
                sel_price = price[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mac_clr     = 1'b0;
        mac_step    = 1'b0;
        latch_total = 1'b0;
        case (state_q)
            IDLE: if (recompute) begin
                state_d = SUM;
                mac_clr = 1'b1;
            end
            SUM: if (sum_idx_q < IDX_W'(N_ITEMS)) begin
                mac_step = 1'b1;
            end else begin
                latch_total = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sum_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (mac_clr)       sum_idx_q <= '0;
            else if (mac_step) sum_idx_q <= sum_idx_q + IDX_W'(1);
        end
    end

    // NOTE: the quantity array is a handful of flops that must start empty,
    // so it is reset like any other register rather than left as RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ITEMS; k++) qty_q[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_ITEMS; k++) begin
                if (op == OP_CLEAR) begin
                    qty_q[k] <= '0;
                end else if (bus.cmd_idx == IDX_W'(k)) begin
                    if (op == OP_ADD && qty_q[k] != QTY_MAX)
                        qty_q[k] <= qty_q[k] + CNT_W'(1);
                    else if (op == OP_REMOVE && qty_q[k] != '0)
                        qty_q[k] <= qty_q[k] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.total_price <= '0;
            bus.total_valid <= 1'b1;
            bus.overflow    <= 1'b0;
            bus.cmd_err     <= 1'b0;
        end else begin
            bus.cmd_err <= accept && !idx_ok && op != OP_CLEAR;
            if (recompute)        bus.total_valid <= 1'b0;
            else if (latch_total) bus.total_valid <= 1'b1;
            if (latch_total) bus.total_price <= {acc_qty, acc_price};
            if (accept && op == OP_CLEAR)
                bus.overflow <= 1'b0;
            else if (accept && op == OP_ADD && idx_ok && cmd_qty == QTY_MAX)
                bus.overflow <= 1'b1;
            else if (latch_total && mac_sat)
                bus.overflow <= 1'b1;
        end
    end

    always_comb begin
        bus.numbers = '0;
        for (int k = 0; k < N_ITEMS; k++)
            bus.numbers[NUM_W-1-SLOT_W*k -: SLOT_W] = {qty_q[k], price[k]};
    end

    cart_mac u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (mac_clr),
        .step      (mac_step),
        .qty       (sel_qty),
        .price     (sel_price),
        .acc_qty   (acc_qty),
        .acc_price (acc_price),
        .sat       (mac_sat)
    );

endmodule

// File: tb/tb_cart_register.sv
// Scoreboard bench for cart_register: a cart model predicts each total,
// and a monitor checks it when total_valid rises.
module tb_cart_register;
    import cart_pkg::*;

    typedef struct {
        logic [19:0] total;
        bit          ovf;
        int          acc_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    int          m_qty   [N_ITEMS];
    int          m_price [N_ITEMS];
    bit          m_ovf;
    logic [19:0] m_total;
    exp_t        sb_q [$];
    logic        prev_valid = 1'b1;

    cart_register_if bus ();

    cart_register dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [239:0] model_numbers();
        logic [239:0] n;
        n = '0;
        for (int k = 0; k < N_ITEMS; k++)
            n[239-20*k -: 20] = {4'(m_qty[k]), 16'(m_price[k])};
        return n;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < N_ITEMS; k++) begin
            m_qty[k]   = 0;
            m_price[k] = 100 * (k + 1);
        end
        m_ovf   = 1'b0;
        m_total = '0;
        sb_q.delete();
    endtask

    // Monitor: compare each completed total against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b1;
        end else begin
            if (bus.total_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_total: got %0h expected none", bus.total_price);
                end else begin
                    e = sb_q.pop_front();
                    check("total_price", bus.total_price, e.total);
                    check("overflow", bus.overflow, e.ovf);
                    check("total_latency", cyc - e.acc_cyc, 13);
                    m_total = e.total;
                end
            end else if (!bus.total_valid) begin
                check("total_hold", bus.total_price, m_total);
            end
            prev_valid = bus.total_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        reset_model();
        @(negedge clk);
        check("rst_numbers", bus.numbers, model_numbers());
        check("rst_total", bus.total_price, 20'h0);
        check("rst_total_valid", bus.total_valid, 1'b1);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_cmd_err", bus.cmd_err, 1'b0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send(input int op, input int idx, input logic [15:0] price);
        int   waited;
        bit   idx_ok, recompute, exp_err;
        int   tq, tp;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_idx   = 4'(idx);
        bus.cmd_price = price;
        waited = 0;
        while (!bus.cmd_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 40) begin
                $display("FAIL ready_timeout: got ready=0 expected 1 within 40 cycles");
                $fatal(1, "cmd_ready never returned");
            end
        end
        @(negedge clk);
        idx_ok    = idx < N_ITEMS;
        exp_err   = !idx_ok && op != 3;
        recompute = 1'b0;
        case (op)
            0: if (idx_ok) begin
                if (m_qty[idx] == 15) m_ovf = 1'b1;
                else m_qty[idx]++;
                recompute = 1'b1;
            end
            1: if (idx_ok) begin
                if (m_qty[idx] > 0) m_qty[idx]--;
                recompute = 1'b1;
            end
            2: if (idx_ok) begin
`ifdef CART_PRICE_LOAD_EN
                m_price[idx] = int'(price);
                recompute = 1'b1;
`endif
            end
            default: begin
                for (int k = 0; k < N_ITEMS; k++) m_qty[k] = 0;
                m_ovf = 1'b0;
                recompute = 1'b1;
            end
        endcase
        if (recompute) begin
            tq = 0;
            tp = 0;
            for (int k = 0; k < N_ITEMS; k++) begin
                tq += m_qty[k];
                tp += m_qty[k] * m_price[k];
            end
            if (tq > 15 || tp > 65535) m_ovf = 1'b1;
            e.total   = {4'(tq > 15 ? 15 : tq), 16'(tp > 65535 ? 65535 : tp)};
            e.ovf     = m_ovf;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        check("numbers", bus.numbers, model_numbers());
        check("cmd_err", bus.cmd_err, exp_err);
        check("valid_after_cmd", bus.total_valid, !recompute);
        check("ready_after_cmd", bus.cmd_ready, !recompute);
        bus.cmd_valid = 1'b0;
        if (exp_err) begin
            @(negedge clk);
            check("cmd_err_single", bus.cmd_err, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.cmd_ready && sb_q.size() == 0)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: got pending=%0d expected 0", sb_q.size());
                break;
            end
        end
    endtask

    initial begin
        int r;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_idx   = '0;
        bus.cmd_price = '0;
        reset_model();
        #1 rst_n = 1'b0;
        do_reset();

        repeat (3) send(0, 2, 16'h0);
        wait_idle();
        check("add3_total", bus.total_price, {4'd3, 16'd900});

        send(3, 0, 16'h0);
        repeat (16) send(0, 0, 16'h0);
        wait_idle();
        check("sat_total", bus.total_price, {4'd15, 16'd1500});
        check("sat_overflow", bus.overflow, 1'b1);
        send(3, 0, 16'h0);
        wait_idle();
        check("clear_total", bus.total_price, 20'h0);
        check("clear_overflow", bus.overflow, 1'b0);

        send(2, 5, 16'hFFFF);
        send(0, 5, 16'h0);
        send(0, 5, 16'h0);
        wait_idle();

        send(0, 12, 16'h0);
        send(2, 13, 16'h1234);
        send(1, 15, 16'h0);
        send(3, 15, 16'h0);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      send(0, $urandom_range(0, 11), 16'h0);
            else if (r < 70) send(1, $urandom_range(0, 11), 16'h0);
            else if (r < 88) send(2, $urandom_range(0, 11),
                                  ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 9000)));
            else if (r < 92) send(3, $urandom_range(0, 15), 16'h0);
            else             send($urandom_range(0, 2), $urandom_range(12, 15), 16'h0);
        end
        wait_idle();

        send(0, 1, 16'h0);
        repeat (4) @(negedge clk);
        do_reset();
        send(0, 3, 16'h0);
        send(0, 11, 16'h0);
        wait_idle();
        check("final_queue", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cart_register.md
# cart_register

Sale-terminal cart state holder and totaliser, directly upstream of the price display writer. Holds per-item quantity and unit price for 12 items and accepts add/remove/price-load/clear commands from the keypad controller. After each state-changing command it recomputes the cart total with a sequential multiply-accumulate sweep. Outputs the packed `numbers` bus and the `total_price` bus the display stage consumes.

## Interface
- `N_ITEMS`, 12: item slots; fixes the `numbers` width at N_ITEMS*20.
- `CNT_W`, 4: quantity field width.
- `PRICE_W`, 16: unit/total price field width.
- `CLK` in 1: system clock.
- `RST_N` in 1: reset; one clock, asynchronous assert, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: 0 ADD, 1 REMOVE, 2 SET_PRICE, 3 CLEAR.
- `cmd_idx` in 4: item slot, 0..N_ITEMS-1.
- `cmd_price` in 16: unit price for SET_PRICE.
- `numbers` out 240: slot k at bits [239-20k -: 20], packed as {qty[3:0], price[15:0]}; slot 0 is the MSBs.
- `total_price` out 20: {total qty saturated at 15, total price saturated at 0xFFFF}.
- `total_valid` out 1: `total_price` matches the current cart.
- `overflow` out 1: sticky; set when a total saturated or a quantity add was clipped.
- `cmd_err` out 1: one-cycle pulse on an accepted command with `cmd_idx >= N_ITEMS`.

## Operation
- FSM states: IDLE, SUM.
- `cmd_ready` = (state == IDLE). A command is accepted on a rising edge with `cmd_valid && cmd_ready`.
- On acceptance, the slot is updated on the same edge:
  - ADD: qty+1, saturating at 15; at 15, set `overflow`.
  - REMOVE: qty-1; no change at 0.
  - SET_PRICE: price := `cmd_price`.
  - CLEAR: all qty := 0, `overflow` := 0; prices are kept.
- After any valid command, FSM goes to SUM with index 0 and accumulators cleared, and `total_valid` drops.
- With `cmd_idx >= N_ITEMS` (ADD/REMOVE/SET_PRICE): no state change, FSM stays IDLE, `cmd_err` pulses. CLEAR ignores `cmd_idx`.
- SUM processes one slot per cycle:
  - acc_price += qty*price, where the 20-bit product is added into a 21-bit accumulator and clamped to 0xFFFF on exceed.
  - acc_qty += qty, clamped to 15.
- After slot N_ITEMS-1, on the next edge: `total_price` := {acc_qty, acc_price}, `total_valid` := 1, FSM → IDLE. Set `overflow` if either clamp fired.
- `total_price` holds its previous value throughout SUM; the display never sees a partial sum.

## Timing
- Reset values:
  - all qty 0; prices from the package default table
  - `total_price` 0, `total_valid` 1, `overflow` 0, `cmd_err` 0
  - `cmd_ready` 1, FSM IDLE
- `numbers` reflects the command 1 edge after acceptance.
- `total_price` updates N_ITEMS+1 = 13 edges after acceptance; `cmd_ready` returns high in that same cycle.
- Commands presented during SUM are stalled, not dropped; `cmd_valid` must hold.
- `RST_N` asserted mid-SUM aborts the sweep immediately and restores all reset values.

## Configuration
- `CART_PRICE_LOAD_EN` defined: SET_PRICE writes the slot price and triggers a recompute.
- Not defined: prices are constants from the package table with no price registers. SET_PRICE is accepted and completes as a no-op: no recompute, `total_valid` stays 1, and `cmd_err` still pulses on an out-of-range index.

## Structure
- Package `cart_pkg`:
  - op code constants
  - N_ITEMS, CNT_W, PRICE_W
  - default price table (slot k = 100*(k+1))
  - saturation limits
- Sub-module `cart_mac`: registered saturating multiply-accumulate with clear, step and sat-flag outputs, instantiated once in the SUM datapath.

## Test plan
- Reset, then read outputs → `numbers` slot 0 = {0, 100}, slot 11 = {0, 1200}; `total_price` = 0; `total_valid` = 1.
- ADD idx 2 three times, waiting for ready → slot 2 qty = 3; `total_price` = {3, 900}; each total arrives 13 cycles after its accept.
- ADD idx 0 sixteen times → qty stops at 15; `overflow` = 1; total = {15, 1500}. Then CLEAR → total {0, 0}, `overflow` 0.
- (With macro) SET_PRICE idx 5 = 0xFFFF, then ADD idx 5 twice → `total_price[15:0]` = 0xFFFF, `overflow` 1.
- Command with `cmd_idx` = 12 → `cmd_err` pulses once; no change on `numbers` or total; `cmd_ready` stays 1.
- ADD idx 1, then drop `RST_N` 5 cycles later → all outputs at reset values next cycle; `total_valid` = 1.
